// File: rtl/simu_mem_framer.sv
// Realigns the memory read strobe to read latency and frames each burst
// as header, data words, trailer into a first-word-fall-through FIFO.
module simu_mem_framer #(
  parameter int          RD_LAT  = 2,
  parameter int          FIFO_AW = 5,
  parameter logic [7:0]  HDR_TAG = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rena,
  input  logic [15:0] mem_dout,
  output logic [15:0] out_data,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        ovf_err,
  output logic        proto_err
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = FIFO_AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TRAILER,
    DROP
  } state_t;

  state_t state, state_n;

  logic [RD_LAT-1:0]  sr;
  logic               dv;
  logic               d1_v;
  logic [15:0]        d1;
  logic [7:0]         evt_cnt, evt_n;
  logic [14:0]        wcnt, wcnt_n;
  logic               frame_ovf, frame_ovf_n;
  logic               set_ovf, set_proto;
  logic               wr_en;
  logic [17:0]        wr_word;
  logic [17:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic               room, rise, pop;
  logic [17:0]        head;

  assign dv   = sr[RD_LAT-1];
  assign rise = dv & ~d1_v;
  // Keep one slot spare so the trailer always fits.
  assign room = count <= CW'(DEPTH - 2);
  assign out_valid = count != '0;
  assign pop  = out_valid & out_ready;
  assign head = mem[rd_ptr];
  assign {out_sop, out_eop, out_data} = out_valid ? head : 18'd0;

  always_comb begin
    state_n     = state;
    evt_n       = evt_cnt;
    wcnt_n      = wcnt;
    frame_ovf_n = frame_ovf;
    set_ovf     = 1'b0;
    set_proto   = 1'b0;
    wr_en       = 1'b0;
    wr_word     = 18'd0;
    unique case (state)
      IDLE: begin
        if (rise) begin
          if (room) begin
            wr_en       = 1'b1;
            wr_word     = {2'b10, HDR_TAG, evt_cnt};
            wcnt_n      = '0;
            frame_ovf_n = 1'b0;
            state_n     = DATA;
          end else begin
            set_ovf = 1'b1;
            state_n = DROP;
          end
        end
      end
      DATA: begin
        if (d1_v) begin
          if (wcnt != 15'h7FFF) wcnt_n = wcnt + 15'd1;
          if (room) begin
            wr_en   = 1'b1;
            wr_word = {2'b00, d1};
          end else begin
            frame_ovf_n = 1'b1;
            set_ovf     = 1'b1;
          end
          if (!dv) state_n = TRAILER;
        end
      end
      TRAILER: begin
        wr_en   = 1'b1;
        wr_word = {2'b01, frame_ovf, wcnt};
        evt_n   = evt_cnt + 8'd1;
        if (dv) begin
          set_proto = 1'b1;
          state_n   = DROP;
        end else begin
          state_n = IDLE;
        end
      end
      DROP: begin
        if (!dv) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr        <= '0;
      d1        <= '0;
      d1_v      <= 1'b0;
      state     <= IDLE;
      evt_cnt   <= '0;
      wcnt      <= '0;
      frame_ovf <= 1'b0;
      ovf_err   <= 1'b0;
      proto_err <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      sr        <= (sr << 1) | RD_LAT'(rena);
      if (dv) d1 <= mem_dout;
      d1_v      <= dv;
      state     <= state_n;
      evt_cnt   <= evt_n;
      wcnt      <= wcnt_n;
      frame_ovf <= frame_ovf_n;
      ovf_err   <= ovf_err | set_ovf;
      proto_err <= proto_err | set_proto;
      if (wr_en) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop) rd_ptr <= rd_ptr + FIFO_AW'(1);
      count     <= count + CW'(wr_en) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_word;
  end

endmodule

// File: tb/tb_simu_mem_framer.sv
// Scoreboard bench for simu_mem_framer: directed bursts, queued
// expected stream words, independent monitor on the output handshake.
module tb_simu_mem_framer;

  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rena = 1'b0;
  logic [15:0] mem_dout;
  logic [15:0] out_data;
  logic        out_sop, out_eop, out_valid;
  logic        out_ready = 1'b0;
  logic        ovf_err, proto_err;

  logic [15:0] word_in = 16'hDEAD;
  logic [15:0] wpipe [4];
  logic [17:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hdr_cyc = -1;
  int rena_cyc = 0;

  simu_mem_framer #(.RD_LAT(RD_LAT), .FIFO_AW(5), .HDR_TAG(8'hA5)) dut (
    .clk(clk), .rst(rst), .rena(rena), .mem_dout(mem_dout),
    .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
    .out_valid(out_valid), .out_ready(out_ready),
    .ovf_err(ovf_err), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    wpipe[0] <= word_in;
    for (int i = 1; i < 4; i++) wpipe[i] <= wpipe[i-1];
  end
  assign mem_dout = wpipe[RD_LAT-1];

  always @(negedge clk) begin
    logic [17:0] got, e;
    if (!rst && out_valid && out_ready) begin
      got = {out_sop, out_eop, out_data};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stream_extra got %h with nothing expected", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL stream got %h exp %h", got, e);
        end
      end
      if (got[17] && hdr_cyc == -2) hdr_cyc = cyc;
    end
  end

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", n, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_frame(input logic [7:0] evt, input int n,
                            input logic [15:0] base, input logic [15:0] step);
    exp_q.push_back({2'b10, 8'hA5, evt});
    for (int i = 0; i < n; i++) exp_q.push_back({2'b00, 16'(base + i * step)});
    exp_q.push_back({2'b01, 16'(n)});
  endtask

  task automatic burst(input int n, input logic [15:0] base,
                       input logic [15:0] step);
    for (int i = 0; i < n; i++) begin
      rena    = 1'b1;
      word_in = 16'(base + i * step);
      tick();
    end
    rena    = 1'b0;
    word_in = 16'hDEAD;
  endtask

  task automatic wait_drain(input string n, input int max);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < max) begin
      tick();
      k++;
    end
    checks++;
    if (exp_q.size() != 0 || out_valid) begin
      errors++;
      $display("FAIL %s drain timeout got %0d pending exp 0", n, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    tick();
    chk("reset_valid", 32'(out_valid), 0);
    chk("reset_word", 32'({out_sop, out_eop, out_data}), 0);
    chk("reset_flags", 32'({ovf_err, proto_err}), 0);
    do_reset();

    // basic frame
    out_ready = 1'b1;
    push_frame(8'h00, 4, 16'h1111, 16'h1111);
    hdr_cyc  = -2;
    rena_cyc = cyc;
    burst(4, 16'h1111, 16'h1111);
    tick(8);
    wait_drain("basic", 50);
    chk("hdr_latency", 32'(hdr_cyc - rena_cyc), 32'(RD_LAT + 1));
    chk("basic_ovf", 32'(ovf_err), 0);

    // 257 single-word frames, event counter wraps
    do_reset();
    for (int i = 0; i < 257; i++) begin
      push_frame(8'(i), 1, 16'(i), 16'h0);
      burst(1, 16'(i), 16'h0);
      tick(5);
    end
    wait_drain("wrap", 50);
    chk("wrap_flags", 32'({ovf_err, proto_err}), 0);

    // backpressure overflow
    do_reset();
    out_ready = 1'b0;
    exp_q.push_back({2'b10, 16'hA500});
    for (int i = 0; i < 30; i++) exp_q.push_back({2'b00, 16'(16'h1000 + i)});
    exp_q.push_back({2'b01, 16'h8028});
    burst(40, 16'h1000, 16'h1);
    tick(6);
    chk("bp_ovf", 32'(ovf_err), 1);
    chk("bp_proto", 32'(proto_err), 0);
    chk("bp_head_sop", 32'({out_valid, out_sop, out_data}), 32'h3A500);
    out_ready = 1'b1;
    wait_drain("bp", 100);
    tick(3);
    chk("bp_empty", 32'(out_valid), 0);

    // full at start: 31 entries then a new burst is dropped
    do_reset();
    out_ready = 1'b0;
    push_frame(8'h00, 29, 16'h2000, 16'h1);
    burst(29, 16'h2000, 16'h1);
    tick(5);
    chk("full_pre_ovf", 32'(ovf_err), 0);
    burst(3, 16'h3000, 16'h1);
    tick(6);
    chk("full_ovf", 32'(ovf_err), 1);
    out_ready = 1'b1;
    wait_drain("full_drain", 100);
    push_frame(8'h01, 2, 16'h4000, 16'h1);
    burst(2, 16'h4000, 16'h1);
    tick(6);
    wait_drain("full_next", 50);

    // gap violation
    do_reset();
    out_ready = 1'b1;
    push_frame(8'h00, 3, 16'h5000, 16'h1);
    burst(3, 16'h5000, 16'h1);
    tick(1);
    burst(2, 16'h6000, 16'h1);
    tick(6);
    chk("gap_proto", 32'(proto_err), 1);
    chk("gap_ovf", 32'(ovf_err), 0);
    wait_drain("gap", 50);
    push_frame(8'h01, 1, 16'h7000, 16'h0);
    burst(1, 16'h7000, 16'h0);
    tick(6);
    wait_drain("gap_next", 50);

    // asynchronous reset during data word 2
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rena    = 1'b1;
      word_in = 16'(16'h8000 + i);
      tick();
      if (i == 5) begin
        chk("mid_valid_pre", 32'(out_valid), 1);
        chk("mid_proto_pre", 32'(proto_err), 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_valid", 32'(out_valid), 0);
        chk("mid_word", 32'({out_sop, out_eop, out_data}), 0);
        chk("mid_flags", 32'({ovf_err, proto_err}), 0);
        break;
      end
    end
    rena    = 1'b0;
    word_in = 16'hDEAD;
    tick(2);
    rst = 1'b0;
    tick(4);
    chk("post_rst_valid", 32'(out_valid), 0);
    out_ready = 1'b1;
    push_frame(8'h00, 2, 16'h9000, 16'h1);
    burst(2, 16'h9000, 16'h1);
    tick(6);
    wait_drain("post_rst", 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
